spike_cnt_window: RTL

SPIKE_CNT_WINDOW -- requirements
Module: spike_cnt_window

---
 rtl/spike_cnt_window.sv | 85 ++++++++
 1 files changed

// File: rtl/spike_cnt_window.sv
// rtl/spike_cnt_window.sv - windowed per-lane spike counter with saturating accumulator.
// Optional feature: SPIKE_CNT_SMOOTH_EN reports the saturating sum of the last 4 closed windows.
module spike_cnt_window #(
  parameter int NLANES    = 16,
  parameter int EDGE_MODE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NLANES-1:0] i_spikes,
  input  logic              i_enable,
  input  logic              i_tick,
  output logic [31:0]       i_spike_cnt,
  output logic              o_cnt_valid,
  output logic              o_sat
);

  logic [NLANES-1:0] r_prev;
  logic [31:0]       r_acc;
  logic [NLANES-1:0] w_events;
  logic [5:0]        w_pop;
  logic [32:0]       w_sum;
  logic [31:0]       w_win;
  logic              w_win_sat;
  logic [31:0]       w_out;

  always_comb begin
    if (EDGE_MODE != 0) w_events = i_spikes & ~r_prev;
    else                w_events = i_spikes;
    w_events = w_events & {NLANES{i_enable}};
  end

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < NLANES; k++) w_pop = w_pop + {5'd0, w_events[k]};
  end

  // This cycle's events always join the window that closes on a tick in this cycle.
  assign w_sum     = {1'b0, r_acc} + {27'd0, w_pop};
  assign w_win_sat = (w_sum >= 33'h0_FFFF_FFFF);
  assign w_win     = w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];

`ifdef SPIKE_CNT_SMOOTH_EN
  logic [31:0] r_hist [3];
  logic [33:0] w_hsum;

  assign w_hsum = {2'b0, w_win} + {2'b0, r_hist[0]} + {2'b0, r_hist[1]} + {2'b0, r_hist[2]};
  assign w_out  = (w_hsum > 34'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : w_hsum[31:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist[0] <= '0;
      r_hist[1] <= '0;
      r_hist[2] <= '0;
    end else if (i_tick) begin
      r_hist[0] <= w_win;
      r_hist[1] <= r_hist[0];
      r_hist[2] <= r_hist[1];
    end
  end
`else
  assign w_out = w_win;
`endif

  // r_prev tracks the raw lines even while disabled, so enable rising mid-pulse adds no edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev      <= '0;
      r_acc       <= '0;
      i_spike_cnt <= '0;
      o_cnt_valid <= 1'b0;
      o_sat       <= 1'b0;
    end else begin
      r_prev      <= i_spikes;
      o_cnt_valid <= i_tick;
      if (w_win_sat) o_sat <= 1'b1;
      if (i_tick) begin
        i_spike_cnt <= w_out;
        r_acc       <= '0;
      end else begin
        r_acc <= w_win;
      end
    end
  end

endmodule
